// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer slice.
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   clog2_min1           : index width for an N-entry select, never below 1 bit
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Handshake bundle between N producers, the multiplexer and one consumer.
//   in_data/in_valid/in_ready : per-channel input streams (channel i at [i*W +: W])
//   mode/sel                  : selection control
//   out_data/out_valid/out_ch : registered output stream, out_ready from the consumer
// master = producers/consumer side, slave = the multiplexer.
interface stream_mux_n_if
  import mux_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned SELW = clog2_min1(N);

  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic [SELW-1:0] out_ch;
  logic            out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req     : per-channel requests
//   ptr     : highest-priority channel; priority falls off ptr, ptr+1, ... wrapping at N
//   gnt     : one-hot grant (all zero when nothing requests)
//   gnt_idx : index of the granted channel (0 when nothing requests)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  localparam int unsigned SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic [SELW-1:0] w_idx;
  logic            w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Modulo keeps the scan inside 0..N-1 when N is not a power of two.
      w_idx = SELW'((32'(ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel, W-bit registered stream multiplexer with fixed or round-robin selection.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (synchronous release expected)
//   bus   : slave side of stream_mux_n_if (inputs, control, registered output)
// One output register stage; a new word loads in the same cycle the old one drains.
module stream_mux_n
  import mux_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input logic           clk,
  input logic           rst_n,
  stream_mux_n_if.slave bus
);

  localparam int unsigned SELW = clog2_min1(N);

  logic [N-1:0]    w_rr_gnt;
  logic [SELW-1:0] w_rr_idx;
  logic [N-1:0]    w_fix_gnt;
  logic [N-1:0]    w_gnt;
  logic [SELW-1:0] w_gnt_idx;
  logic            w_any;
  logic            w_load;
  logic [W-1:0]    w_data;

  logic [SELW-1:0] r_rr_ptr;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_ch;
  logic            r_out_valid;

  rr_arbiter #(
    .N(N)
  ) u_rr_arbiter (
    .req     (bus.in_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_rr_gnt),
    .gnt_idx (w_rr_idx)
  );

  // Compare sel against each legal index so sel >= N simply matches nothing.
  always_comb begin
    w_fix_gnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
        w_fix_gnt[i] = 1'b1;
      end
    end
  end

  always_comb begin
    if (bus.mode == MODE_FIXED) begin
      w_gnt     = w_fix_gnt;
      w_gnt_idx = bus.sel;
    end else begin
      w_gnt     = w_rr_gnt;
      w_gnt_idx = w_rr_idx;
    end
  end

  always_comb begin
    w_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_data = bus.in_data[i*W +: W];
      end
    end
  end

  assign w_any  = |w_gnt;
  // Output register may take a new word when empty or draining this cycle.
  assign w_load = ~r_out_valid | bus.out_ready;

  assign bus.in_ready  = {N{w_load}} & w_gnt;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_ch    <= w_gnt_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Pointer advances past the winner only for round-robin grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_load && w_any && bus.mode == MODE_RR) begin
      r_rr_ptr <= (w_gnt_idx == SELW'(N - 1)) ? '0 : w_gnt_idx + SELW'(1);
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
module tb_stream_mux_n;
  import mux_pkg::*;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t q4[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  stream_mux_n_if #(.N(4), .W(8)) bus4 ();
  stream_mux_n_if #(.N(3), .W(8)) bus3 ();

  stream_mux_n #(.N(4), .W(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  stream_mux_n #(.N(3), .W(8)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pop and compare on an output transfer, then advance to 1 time unit past the edge.
  task automatic cycle4();
    exp_t e;
    if (bus4.out_valid === 1'b1 && bus4.out_ready === 1'b1) begin
      chk("sb4_nonempty", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("out_ch4", 32'(bus4.out_ch), 32'(e.ch));
        chk("out_data4", 32'(bus4.out_data), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle3();
    exp_t e;
    if (bus3.out_valid === 1'b1 && bus3.out_ready === 1'b1) begin
      chk("sb3_nonempty", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("out_ch3", 32'(bus3.out_ch), 32'(e.ch));
        chk("out_data3", 32'(bus3.out_data), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    logic [1:0] seq [3];
    seq[0] = 2'd3;
    seq[1] = 2'd0;
    seq[2] = 2'd3;

    bus4.in_data = '0; bus4.in_valid = '0; bus4.mode = MODE_FIXED;
    bus4.sel = '0; bus4.out_ready = 1'b0;
    bus3.in_data = '0; bus3.in_valid = '0; bus3.mode = MODE_FIXED;
    bus3.sel = '0; bus3.out_ready = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid4", 32'(bus4.out_valid), 32'd0);
    chk("rst_data4", 32'(bus4.out_data), 32'd0);
    chk("rst_ch4", 32'(bus4.out_ch), 32'd0);
    chk("rst_valid3", 32'(bus3.out_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. Fixed mode, sel=2
    bus4.out_ready = 1'b1;
    bus4.sel       = 2'd2;
    bus4.in_valid  = 4'b0100;
    bus4.in_data   = {8'h00, 8'hC3, 8'h00, 8'h00};
    #1 chk("fix_in_ready", 32'(bus4.in_ready), 32'h4);
    q4.push_back('{ch: 2'd2, data: 8'hC3});
    cycle4();
    chk("fix_valid", 32'(bus4.out_valid), 32'd1);
    bus4.in_valid = '0;
    cycle4();
    chk("fix_drain_valid", 32'(bus4.out_valid), 32'd0);
    // Selected channel not valid: no grant even though others are valid
    bus4.sel      = 2'd1;
    bus4.in_valid = 4'b1101;
    #1 chk("fix_nogrant_ready", 32'(bus4.in_ready), 32'h0);
    cycle4();
    chk("fix_nogrant_valid", 32'(bus4.out_valid), 32'd0);

    // 2. Round-robin fairness, all channels valid, data = index
    bus4.mode     = MODE_RR;
    bus4.in_valid = 4'b1111;
    bus4.in_data  = {8'd3, 8'd2, 8'd1, 8'd0};
    for (int k = 0; k < 6; k++) begin
      oh = 4'(1 << (k % 4));
      #1 chk("rr_in_ready", 32'(bus4.in_ready), 32'(oh));
      q4.push_back('{ch: 2'(k % 4), data: 8'(k % 4)});
      cycle4();
      chk("rr_valid", 32'(bus4.out_valid), 32'd1);
    end

    // 3. Backpressure: held word ch1 stays put, nothing granted
    bus4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", 32'(bus4.in_ready), 32'h0);
      chk("bp_ch", 32'(bus4.out_ch), 32'd1);
      chk("bp_data", 32'(bus4.out_data), 32'd1);
      cycle4();
    end
    bus4.out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus4.in_ready), 32'h4);
    q4.push_back('{ch: 2'd2, data: 8'd2});
    cycle4();
    chk("bp_reload_ch", 32'(bus4.out_ch), 32'd2);
    bus4.in_valid = '0;
    cycle4();
    chk("bp_end_valid", 32'(bus4.out_valid), 32'd0);

    // 4. RR skip: pointer is 3, single ch0 word moves it to 1
    bus4.in_valid = 4'b0001;
    #1 chk("skip_pre_ready", 32'(bus4.in_ready), 32'h1);
    q4.push_back('{ch: 2'd0, data: 8'd0});
    cycle4();
    bus4.in_valid = 4'b1001;
    bus4.in_data  = {8'hA3, 8'h02, 8'h01, 8'hA0};
    for (int k = 0; k < 3; k++) begin
      oh = 4'(1 << seq[k]);
      #1 chk("skip_in_ready", 32'(bus4.in_ready), 32'(oh));
      q4.push_back('{ch: seq[k], data: (seq[k] == 2'd3) ? 8'hA3 : 8'hA0});
      cycle4();
    end
    bus4.in_valid = '0;
    cycle4();
    chk("skip_end_valid", 32'(bus4.out_valid), 32'd0);

    // 5. Reset mid-stream with a word held, pointer moved to 2
    bus4.in_data  = {8'd3, 8'd2, 8'd1, 8'd0};
    bus4.in_valid = 4'b0010;
    #1 chk("mid_pre_ready", 32'(bus4.in_ready), 32'h2);
    q4.push_back('{ch: 2'd1, data: 8'd1});
    cycle4();
    bus4.in_valid  = '0;
    bus4.out_ready = 1'b0;
    #2 chk("mid_held_valid", 32'(bus4.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus4.out_valid), 32'd0);
    chk("mid_rst_data", 32'(bus4.out_data), 32'd0);
    chk("mid_rst_ch", 32'(bus4.out_ch), 32'd0);
    q4.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(bus4.in_ready), 32'h1);
    q4.push_back('{ch: 2'd0, data: 8'd0});
    cycle4();
    bus4.in_valid = '0;
    cycle4();
    chk("post_rst_end_valid", 32'(bus4.out_valid), 32'd0);

    // 6. N=3, fixed, out-of-range select
    bus3.mode     = MODE_FIXED;
    bus3.sel      = 2'd0;
    bus3.in_valid = 3'b111;
    bus3.in_data  = {8'h32, 8'h31, 8'h30};
    #1 chk("n3_sel0_ready", 32'(bus3.in_ready), 32'h1);
    q3.push_back('{ch: 2'd0, data: 8'h30});
    cycle3();
    bus3.sel = 2'd3;
    #1 chk("n3_sel3_ready_bp", 32'(bus3.in_ready), 32'h0);
    cycle3();
    chk("n3_held_valid", 32'(bus3.out_valid), 32'd1);
    chk("n3_held_ch", 32'(bus3.out_ch), 32'd0);
    bus3.out_ready = 1'b1;
    #1 chk("n3_sel3_ready", 32'(bus3.in_ready), 32'h0);
    cycle3();
    chk("n3_drain_valid", 32'(bus3.out_valid), 32'd0);
    cycle3();
    chk("n3_idle_valid", 32'(bus3.out_valid), 32'd0);
    chk("n3_idle_ready", 32'(bus3.in_ready), 32'h0);

    chk("sb4_empty", 32'(q4.size()), 32'd0);
    chk("sb3_empty", 32'(q3.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
